vending_credit_fsm: RTL and testbench

- Parametrised successor to the single-shot vending controller: accumulates coin credit across multiple insertions and serves N products with runtime-programmable prices.
- Returns change unit-by-unit; refunds on cancel or inactivity timeout; reports errors with a hold time.
- Sits between the debounced button/coin front end and the dispense/display logic (7-seg shows Credit and Err_code).
- Runs entirely on one clock; all hold/timeout durations are cycle counts.

---
 rtl/vending_credit_fsm.sv | 146 ++++++++++++++
 tb/tb_vending_credit_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vending_credit_fsm.sv
// vending_credit_fsm: multi-coin credit vending controller with programmable prices,
// unit-by-unit change, cancel/timeout refund and held error reporting.
module vending_credit_fsm #(
    parameter int NUM_PRODUCTS   = 4,
    parameter int CREDIT_W       = 6,
    parameter int MAX_CREDIT     = 16,
    parameter int DISP_CYCLES    = 6,
    parameter int CHG_PERIOD     = 4,
    parameter int ERR_CYCLES     = 6,
    parameter int TIMEOUT_CYCLES = 600
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             Coin_valid,
    input  logic [1:0]                       Coin_value,
    input  logic [NUM_PRODUCTS-1:0]          Sel,
    input  logic                             Cancel,
    input  logic [NUM_PRODUCTS-1:0]          Sold_out,
    input  logic [NUM_PRODUCTS*CREDIT_W-1:0] Price,
    output logic [NUM_PRODUCTS-1:0]          Disp,
    output logic                             Chg_pulse,
    output logic                             Coin_reject,
    output logic [CREDIT_W-1:0]              Credit,
    output logic                             Busy,
    output logic                             Err,
    output logic [1:0]                       Err_code
);
    typedef enum logic [2:0] {IDLE, CREDIT, DISPENSE, CHANGE, ERROR} state_t;
    localparam int M1 = DISP_CYCLES > CHG_PERIOD ? DISP_CYCLES : CHG_PERIOD;
    localparam int M2 = M1 > ERR_CYCLES ? M1 : ERR_CYCLES;
    localparam int M3 = M2 > TIMEOUT_CYCLES ? M2 : TIMEOUT_CYCLES;
    localparam int CW = $clog2(M3 + 1);
    localparam logic [CW-1:0] DISP_LAST = CW'(DISP_CYCLES - 1);
    localparam logic [CW-1:0] CHG_LAST  = CW'(CHG_PERIOD - 1);
    localparam logic [CW-1:0] ERR_LAST  = CW'(ERR_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CREDIT_W-1:0] credit, credit_n, price_sel;
    logic [CREDIT_W:0] coin_u, sum;
    logic [NUM_PRODUCTS-1:0] sel_q, sel_n;
    logic [1:0] code, code_n;
    logic rej, rej_n, coin_ok, so_sel, open;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            credit <= '0;
            sel_q  <= '0;
            code   <= '0;
            rej    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            credit <= credit_n;
            sel_q  <= sel_n;
            code   <= code_n;
            rej    <= rej_n;
        end
    end

    always_comb begin
        coin_u    = (Coin_value == 2'b11) ? (CREDIT_W + 1)'(4) : (CREDIT_W + 1)'(Coin_value);
        sum       = {1'b0, credit} + coin_u;
        coin_ok   = (Coin_value != 2'b00) && (sum <= MAX_C);
        open      = (state == IDLE) || (state == CREDIT);
        price_sel = '0;
        so_sel    = 1'b0;
        for (int k = 0; k < NUM_PRODUCTS; k++)
            if (Sel[k]) begin
                price_sel = Price[k*CREDIT_W +: CREDIT_W];
                so_sel    = Sold_out[k];
            end
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        credit_n = credit;
        sel_n    = sel_q;
        code_n   = code;
        rej_n    = Coin_valid && !(open && coin_ok);
        case (state)
            IDLE, CREDIT: begin
                // any coin strobe, accepted or not, outranks Cancel/Sel this cycle
                if (Coin_valid) begin
                    cnt_n = '0;
                    if (coin_ok) begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = CREDIT;
                    end
                end else if (Cancel && state == CREDIT) begin
                    state_n = CHANGE;
                    cnt_n   = '0;
                end else if (|Sel) begin
                    cnt_n   = '0;
                    state_n = ERROR;
                    if ((Sel & (Sel - NUM_PRODUCTS'(1))) != '0) code_n = 2'b11;
                    else if (so_sel) code_n = 2'b10;
                    else if (credit < price_sel) code_n = 2'b01;
                    else begin
                        credit_n = credit - price_sel;
                        sel_n    = Sel;
                        state_n  = DISPENSE;
                    end
                end else if (state == CREDIT && cnt == TO_LAST) begin
                    state_n = CHANGE;
                    cnt_n   = '0;
                end
            end
            DISPENSE: if (cnt == DISP_LAST) begin
                state_n = (credit != '0) ? CHANGE : IDLE;
                cnt_n   = '0;
                sel_n   = '0;
            end
            CHANGE: begin
                if (credit == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    credit_n = credit - CREDIT_W'(1);
                    if (credit == CREDIT_W'(1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (cnt == CHG_LAST) cnt_n = '0;
            end
            ERROR: if (cnt == ERR_LAST) begin
                state_n = (credit != '0) ? CREDIT : IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign Disp        = (state == DISPENSE) ? sel_q : '0;
    assign Chg_pulse   = (state == CHANGE) && (cnt == '0) && (credit != '0);
    assign Coin_reject = rej;
    assign Credit      = credit;
    assign Busy        = (state == DISPENSE) || (state == CHANGE) || (state == ERROR);
    assign Err         = (state == ERROR);
    assign Err_code    = Err ? code : 2'b00;
endmodule

// File: tb/tb_vending_credit_fsm.sv
// tb_vending_credit_fsm: directed self-checking bench for vending_credit_fsm with default parameters.
module tb_vending_credit_fsm;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Coin_valid = 1'b0;
    logic [1:0]  Coin_value = 2'b00;
    logic [3:0]  Sel = '0;
    logic        Cancel = 1'b0;
    logic [3:0]  Sold_out = '0;
    logic [23:0] Price = {6'd5, 6'd4, 6'd3, 6'd2};
    logic [3:0]  Disp;
    logic        Chg_pulse, Coin_reject, Busy, Err;
    logic [5:0]  Credit;
    logic [1:0]  Err_code;
    int total = 0, bad = 0, nd, nc, ne, np;
    int pos [0:3];

    vending_credit_fsm dut (
        .CLK(CLK), .RST_N(RST_N), .Coin_valid(Coin_valid), .Coin_value(Coin_value),
        .Sel(Sel), .Cancel(Cancel), .Sold_out(Sold_out), .Price(Price),
        .Disp(Disp), .Chg_pulse(Chg_pulse), .Coin_reject(Coin_reject), .Credit(Credit),
        .Busy(Busy), .Err(Err), .Err_code(Err_code)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [1:0] v);
        Coin_valid = 1'b1;
        Coin_value = v;
        @(negedge CLK);
        Coin_valid = 1'b0;
        Coin_value = 2'b00;
    endtask

    task automatic pick(input logic [3:0] s);
        Sel = s;
        @(negedge CLK);
        Sel = '0;
    endtask

    task automatic watch(input int n);
        nd = 0; nc = 0; ne = 0;
        repeat (n) begin
            nd += int'(Disp != '0);
            nc += int'(Chg_pulse);
            ne += int'(Err);
            @(negedge CLK);
        end
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_credit", Credit, 0);
        chk("rst_outs", {Disp, Chg_pulse, Coin_reject, Busy, Err, Err_code}, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        // two single units, buy product 0 at price 2
        coin(2'b01);
        chk("t1_credit1", Credit, 1);
        coin(2'b01);
        chk("t1_credit2", Credit, 2);
        pick(4'b0001);
        chk("t1_disp", Disp, 4'b0001);
        chk("t1_credit0", Credit, 0);
        watch(10);
        chk("t1_disp_len", nd, 6);
        chk("t1_no_chg", nc, 0);
        chk("t1_idle", Busy, 0);
        // four units, product 1 at price 3, one unit of change
        coin(2'b11);
        chk("t2_credit4", Credit, 4);
        pick(4'b0010);
        chk("t2_disp", Disp, 4'b0010);
        watch(20);
        chk("t2_disp_len", nd, 6);
        chk("t2_chg", nc, 1);
        chk("t2_credit0", Credit, 0);
        chk("t2_idle", Busy, 0);
        // error codes with one unit of credit
        coin(2'b01);
        pick(4'b0100);
        chk("t3_err_ins", {Err, Err_code}, 3'b101);
        chk("t3_credit", Credit, 1);
        watch(10);
        chk("t3_err_len", ne, 6);
        chk("t3_back_credit", {Busy, Credit}, 7'd1);
        Sold_out = 4'b1000;
        pick(4'b1000);
        chk("t3_err_so", {Err, Err_code}, 3'b110);
        watch(10);
        pick(4'b0011);
        chk("t3_err_multi", {Err, Err_code}, 3'b111);
        watch(10);
        chk("t3_err_len2", ne, 6);
        Sold_out = '0;
        // credit ceiling and rejects
        coin(2'b11); coin(2'b11); coin(2'b11); coin(2'b01);
        chk("t4_credit14", Credit, 14);
        coin(2'b11);
        chk("t4_rej_over", {Coin_reject, Credit}, {1'b1, 6'd14});
        @(negedge CLK);
        chk("t4_rej_pulse", Coin_reject, 0);
        coin(2'b10);
        chk("t4_credit16", {Coin_reject, Credit}, {1'b0, 6'd16});
        coin(2'b00);
        chk("t4_rej_zero", {Coin_reject, Credit}, {1'b1, 6'd16});
        pick(4'b1000);
        chk("t4_disp", {Disp, Credit}, {4'b1000, 6'd11});
        coin(2'b01);
        chk("t4_rej_busy", {Coin_reject, Credit}, {1'b1, 6'd11});
        watch(80);
        chk("t4_chg11", nc, 11);
        chk("t4_end", {Busy, Credit}, 0);
        // cancel refund of three units, pulses every 4 cycles
        coin(2'b01); coin(2'b10);
        Cancel = 1'b1;
        @(negedge CLK);
        Cancel = 1'b0;
        chk("t5_first_pulse", {Chg_pulse, Credit}, {1'b1, 6'd3});
        np = 0;
        for (int i = 0; i < 12; i++) begin
            if (Chg_pulse && np < 4) begin pos[np] = i; np++; end
            if (i == 1) chk("t5_credit2", Credit, 2);
            if (i == 5) chk("t5_credit1", Credit, 1);
            if (i == 9) chk("t5_idle", {Busy, Credit}, 0);
            @(negedge CLK);
        end
        chk("t5_npulse", np, 3);
        chk("t5_spacing", {pos[1][7:0], pos[2][7:0]}, {8'd4, 8'd8});
        // coin and cancel together: coin wins, refund includes it
        coin(2'b10);
        Coin_valid = 1'b1; Coin_value = 2'b01; Cancel = 1'b1;
        @(negedge CLK);
        Coin_valid = 1'b0; Coin_value = 2'b00;
        chk("t5_coin_first", {Busy, Credit}, {1'b0, 6'd3});
        @(negedge CLK);
        Cancel = 1'b0;
        watch(20);
        chk("t5_refund3", nc, 3);
        chk("t5_refund_end", {Busy, Credit}, 0);
        // inactivity timeout
        coin(2'b10);
        repeat (599) @(negedge CLK);
        chk("t6_pre_timeout", {Busy, Credit}, {1'b0, 6'd2});
        @(negedge CLK);
        chk("t6_timeout", {Busy, Chg_pulse}, 2'b11);
        watch(20);
        chk("t6_refund2", nc, 2);
        chk("t6_end", {Busy, Credit}, 0);
        // asynchronous reset mid-dispense
        coin(2'b11);
        pick(4'b0001);
        chk("t7_disp", Disp, 4'b0001);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("t7_rst_async", {Disp, Busy, Credit}, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("t7_after", {Disp, Busy, Err, Credit}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
